decoder_stage_controller: RTL and testbench

Central sequencer for the single-FPGA union-find decoder PE array. It drives the broadcast `global_stage` and `context_id` that every PE samples. It decides when growth/merge converges from the OR-reduced PE `busy`/`odd` flags, and it rotates through PE memory contexts using `STAGE_WRITE_TO_MEM`. It exposes a start handshake toward the measurement source and a result handshake toward the error-readout logic.

---
 rtl/decoder_stage_controller_pkg.sv | 43 ++++
 rtl/decoder_stage_controller_if.sv | 29 ++
 rtl/merge_convergence_detector.sv | 48 ++++
 rtl/decoder_stage_controller.sv | 164 ++++++++++++++++
 tb/tb_decoder_stage_controller.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage broadcast codes and controller state encoding for the UF decoder.
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd6;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESET_ROOTS         = 3'd7;

  // WR states are split by phase so the FSM knows what follows the context swap.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_WR,
    ST_GROW,
    ST_MERGE,
    ST_SEEK_WR,
    ST_PEEL,
    ST_PEEL_WR,
    ST_RESULT,
    ST_RESET_ROOTS
  } ctrl_state_t;

  function automatic logic [STAGE_WIDTH-1:0] stage_of(input ctrl_state_t s);
    case (s)
      ST_LOAD:                      stage_of = STAGE_MEASUREMENT_LOADING;
      ST_GROW:                      stage_of = STAGE_GROW;
      ST_MERGE:                     stage_of = STAGE_MERGE;
      ST_PEEL:                      stage_of = STAGE_PEELING;
      ST_RESULT:                    stage_of = STAGE_RESULT_VALID;
      ST_LOAD_WR, ST_SEEK_WR,
      ST_PEEL_WR:                   stage_of = STAGE_WRITE_TO_MEM;
      ST_RESET_ROOTS:               stage_of = STAGE_RESET_ROOTS;
      default:                      stage_of = STAGE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/decoder_stage_controller_if.sv
// Start/result handshakes, PE status reduction inputs and stage broadcast.
interface decoder_stage_controller_if #(
  parameter int CTX_W          = 1,
  parameter int GROW_CNT_WIDTH = 6
);
  import decoder_stage_controller_pkg::*;

  logic                      start;
  logic                      start_ready;
  logic                      busy_any;
  logic                      odd_any;
  logic [STAGE_WIDTH-1:0]    global_stage;
  logic [CTX_W-1:0]          context_id;
  logic                      result_valid;
  logic                      result_ready;
  logic [GROW_CNT_WIDTH-1:0] grow_count;
  logic                      timeout;

  modport master (
    input  start, busy_any, odd_any, result_ready,
    output start_ready, global_stage, context_id, result_valid, grow_count, timeout
  );

  modport slave (
    output start, busy_any, odd_any, result_ready,
    input  start_ready, global_stage, context_id, result_valid, grow_count, timeout
  );

endinterface

// File: rtl/merge_convergence_detector.sv
// Merge quiet-period counter and per-context odd-cluster flags.
module merge_convergence_detector #(
  parameter int NUM_CONTEXTS = 2,
  parameter int MERGE_QUIET  = 3,
  parameter int CTX_W        = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_active,
  input  logic                    i_busy_any,
  input  logic                    i_odd_any,
  input  logic                    i_clear,
  input  logic [CTX_W-1:0]        i_ctx,
  output logic                    o_done,
  output logic [NUM_CONTEXTS-1:0] o_ctx_odd,
  output logic [NUM_CONTEXTS-1:0] o_ctx_odd_nxt
);
  localparam int QW = $clog2(MERGE_QUIET + 1);

  logic [QW-1:0]           r_quiet;
  logic [NUM_CONTEXTS-1:0] r_ctx_odd;

  // Done on the cycle that would complete MERGE_QUIET consecutive quiet cycles.
  assign o_done    = i_active && !i_busy_any && (r_quiet == QW'(MERGE_QUIET - 1));
  assign o_ctx_odd = r_ctx_odd;

  // Flag vector as it will be after this edge, so the FSM decides on fresh data.
  always_comb begin
    o_ctx_odd_nxt = r_ctx_odd;
    for (int i = 0; i < NUM_CONTEXTS; i++)
      if (o_done && i_ctx == CTX_W'(i)) o_ctx_odd_nxt[i] = i_odd_any;
  end

  // Quiet count restarts outside MERGE, on any busy cycle and after exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_quiet <= '0;
    else if (!i_active || i_busy_any || o_done) r_quiet <= '0;
    else                                      r_quiet <= r_quiet + QW'(1);
  end

  // Every context starts a round presumed odd; merges overwrite their own bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ctx_odd <= '0;
    else if (i_clear) r_ctx_odd <= '1;
    else              r_ctx_odd <= o_ctx_odd_nxt;
  end

endmodule

// File: rtl/decoder_stage_controller.sv
// Round sequencer for the union-find PE array: load, grow/merge, peel, result.
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int NUM_CONTEXTS   = 2,
  parameter int GROW_CYCLES    = 2,
  parameter int MERGE_QUIET    = 3,
  parameter int MAX_GROW       = 63,
  parameter int GROW_CNT_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  decoder_stage_controller_if.master bus
);
  localparam int CTX_W = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;
  localparam int CYC_W = $clog2(GROW_CYCLES + NUM_CONTEXTS + 1);
  localparam bit MULTI = (NUM_CONTEXTS > 1);
  localparam logic [CTX_W-1:0] LAST_CTX = CTX_W'(NUM_CONTEXTS - 1);

  ctrl_state_t               r_state, w_state_nxt;
  logic [STAGE_WIDTH-1:0]    r_stage;
  logic [CTX_W-1:0]          r_ctx, w_ctx_nxt, w_ctx_inc;
  logic [GROW_CNT_WIDTH-1:0] r_grow, w_grow_nxt, w_grow_inc;
  logic [CYC_W-1:0]          r_cyc, w_cyc_nxt;
  logic                      r_timeout, w_timeout_nxt;
  logic                      r_result_valid, r_start_ready;
  logic                      w_clear_odd, w_merge_done, w_in_merge, w_inc_odd;
  logic [NUM_CONTEXTS-1:0]   w_ctx_odd, w_ctx_odd_nxt;

  assign w_ctx_inc  = (r_ctx == LAST_CTX) ? '0 : r_ctx + CTX_W'(1);
  assign w_grow_inc = (&r_grow) ? r_grow : r_grow + GROW_CNT_WIDTH'(1);
  assign w_in_merge = (r_state == ST_MERGE);

  assign bus.global_stage = r_stage;
  assign bus.context_id   = r_ctx;
  assign bus.grow_count   = r_grow;
  assign bus.timeout      = r_timeout;
  assign bus.result_valid = r_result_valid;
  assign bus.start_ready  = r_start_ready;

  merge_convergence_detector #(
    .NUM_CONTEXTS(NUM_CONTEXTS),
    .MERGE_QUIET (MERGE_QUIET),
    .CTX_W       (CTX_W)
  ) u_merge (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_active     (w_in_merge),
    .i_busy_any   (bus.busy_any),
    .i_odd_any    (bus.odd_any),
    .i_clear      (w_clear_odd),
    .i_ctx        (r_ctx),
    .o_done       (w_merge_done),
    .o_ctx_odd    (w_ctx_odd),
    .o_ctx_odd_nxt(w_ctx_odd_nxt)
  );

  // Odd flag of the context that a WRITE_TO_MEM would rotate in next.
  always_comb begin
    w_inc_odd = 1'b0;
    for (int i = 0; i < NUM_CONTEXTS; i++)
      if (w_ctx_inc == CTX_W'(i)) w_inc_odd = w_ctx_odd[i];
  end

  // Next-state, context rotation and round counters.
  always_comb begin
    w_state_nxt   = r_state;
    w_ctx_nxt     = r_ctx;
    w_grow_nxt    = r_grow;
    w_timeout_nxt = r_timeout;
    w_cyc_nxt     = r_cyc;
    w_clear_odd   = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.start && r_start_ready) begin
        w_state_nxt   = ST_LOAD;
        w_ctx_nxt     = '0;
        w_grow_nxt    = '0;
        w_timeout_nxt = 1'b0;
        w_clear_odd   = 1'b1;
      end
      ST_LOAD: if (MULTI) w_state_nxt = ST_LOAD_WR;
      else begin
        w_state_nxt = ST_GROW;
        w_grow_nxt  = w_grow_inc;
        w_cyc_nxt   = '0;
      end
      ST_LOAD_WR: begin
        w_ctx_nxt = w_ctx_inc;
        if (r_ctx == LAST_CTX) begin
          w_state_nxt = ST_GROW;
          w_grow_nxt  = w_grow_inc;
          w_cyc_nxt   = '0;
        end else w_state_nxt = ST_LOAD;
      end
      ST_GROW: if (r_cyc == CYC_W'(GROW_CYCLES - 1)) begin
        w_state_nxt = ST_MERGE;
        w_cyc_nxt   = '0;
      end else w_cyc_nxt = r_cyc + CYC_W'(1);
      ST_MERGE: if (w_merge_done) begin
        if (w_ctx_odd_nxt == '0) begin
          w_state_nxt = ST_PEEL;
          w_cyc_nxt   = '0;
        end else if (r_grow == GROW_CNT_WIDTH'(MAX_GROW)) begin
          w_state_nxt   = ST_PEEL;
          w_timeout_nxt = 1'b1;
          w_cyc_nxt     = '0;
        end else if (MULTI) w_state_nxt = ST_SEEK_WR;
        else begin
          w_state_nxt = ST_GROW;
          w_grow_nxt  = w_grow_inc;
          w_cyc_nxt   = '0;
        end
      end
      // Keep rotating until a context with odd clusters is live.
      ST_SEEK_WR: begin
        w_ctx_nxt = w_ctx_inc;
        if (w_inc_odd) begin
          w_state_nxt = ST_GROW;
          w_grow_nxt  = w_grow_inc;
          w_cyc_nxt   = '0;
        end
      end
      ST_PEEL: w_state_nxt = MULTI ? ST_PEEL_WR : ST_RESULT;
      ST_PEEL_WR: begin
        w_ctx_nxt = w_ctx_inc;
        if (r_cyc == CYC_W'(NUM_CONTEXTS - 1)) w_state_nxt = ST_RESULT;
        else begin
          w_state_nxt = ST_PEEL;
          w_cyc_nxt   = r_cyc + CYC_W'(1);
        end
      end
      ST_RESULT: if (bus.result_ready) w_state_nxt = ST_RESET_ROOTS;
      ST_RESET_ROOTS: begin
        w_state_nxt = ST_IDLE;
        w_ctx_nxt   = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // All outputs are registered from the next state so PEs see glitch-free codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_stage        <= STAGE_IDLE;
      r_ctx          <= '0;
      r_grow         <= '0;
      r_cyc          <= '0;
      r_timeout      <= 1'b0;
      r_result_valid <= 1'b0;
      r_start_ready  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_stage        <= stage_of(w_state_nxt);
      r_ctx          <= w_ctx_nxt;
      r_grow         <= w_grow_nxt;
      r_cyc          <= w_cyc_nxt;
      r_timeout      <= w_timeout_nxt;
      r_result_valid <= (w_state_nxt == ST_RESULT);
      r_start_ready  <= (w_state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Trace-level checks of the stage controller against a round-procedure model.
module tb_decoder_stage_controller;
  import decoder_stage_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic tb_start = 1'b0, tb_busy = 1'b0, tb_odd = 1'b0, tb_ready = 1'b0;
  int   sel = 0;
  int   checks = 0;
  int   errors = 0;

  // A: one context; B: two contexts; C: one context with MAX_GROW=3
  decoder_stage_controller_if #(.CTX_W(1), .GROW_CNT_WIDTH(6)) if_a();
  decoder_stage_controller_if #(.CTX_W(1), .GROW_CNT_WIDTH(6)) if_b();
  decoder_stage_controller_if #(.CTX_W(1), .GROW_CNT_WIDTH(6)) if_c();

  assign if_a.start = tb_start && (sel == 0);
  assign if_b.start = tb_start && (sel == 1);
  assign if_c.start = tb_start && (sel == 2);
  assign if_a.busy_any = tb_busy;  assign if_b.busy_any = tb_busy;  assign if_c.busy_any = tb_busy;
  assign if_a.odd_any  = tb_odd;   assign if_b.odd_any  = tb_odd;   assign if_c.odd_any  = tb_odd;
  assign if_a.result_ready = tb_ready;
  assign if_b.result_ready = tb_ready;
  assign if_c.result_ready = tb_ready;

  decoder_stage_controller #(.NUM_CONTEXTS(1), .GROW_CYCLES(2), .MERGE_QUIET(3),
    .MAX_GROW(63), .GROW_CNT_WIDTH(6)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  decoder_stage_controller #(.NUM_CONTEXTS(2), .GROW_CYCLES(2), .MERGE_QUIET(3),
    .MAX_GROW(63), .GROW_CNT_WIDTH(6)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  decoder_stage_controller #(.NUM_CONTEXTS(1), .GROW_CYCLES(2), .MERGE_QUIET(3),
    .MAX_GROW(3), .GROW_CNT_WIDTH(6)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic [2:0] m_stage;
  logic       m_ctx, m_rv, m_sr, m_to;
  logic [5:0] m_grow;

  always_comb begin
    m_stage = if_a.global_stage; m_ctx = if_a.context_id; m_grow = if_a.grow_count;
    m_to = if_a.timeout; m_rv = if_a.result_valid; m_sr = if_a.start_ready;
    if (sel == 1) begin
      m_stage = if_b.global_stage; m_ctx = if_b.context_id; m_grow = if_b.grow_count;
      m_to = if_b.timeout; m_rv = if_b.result_valid; m_sr = if_b.start_ready;
    end else if (sel == 2) begin
      m_stage = if_c.global_stage; m_ctx = if_c.context_id; m_grow = if_c.grow_count;
      m_to = if_c.timeout; m_rv = if_c.result_valid; m_sr = if_c.start_ready;
    end
  end

  // Model configuration for the next round
  int m_nc = 1, m_maxg = 63, busy_mode = 0, rdy_delay = 0;
  int odd_limit [2];
  // Expected per-cycle trace and the inputs to drive on each cycle
  int e_stage[$], e_ctx[$], e_grow[$], e_to[$], d_busy[$], d_odd[$], d_ready[$];
  // Observed tallies from the last round
  int obs_merge, obs_peel, obs_grow_c1, obs_last_grow;

  function automatic int rnd();
    return int'($urandom_range(0, 1));
  endfunction

  function automatic int busy_at(input int k);
    case (busy_mode)
      1:       return (k < 10 && $urandom_range(0, 2) == 0) ? 1 : 0;
      2:       return (k < 5) ? 1 : 0;
      3:       return (k == 2) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic push(input logic [2:0] st, input int c, input int g, input int to,
                      input int b, input int o, input int r);
    e_stage.push_back(int'(st)); e_ctx.push_back(c); e_grow.push_back(g); e_to.push_back(to);
    d_busy.push_back(b); d_odd.push_back(o); d_ready.push_back(r);
  endtask

  // Walks one round as a procedure: load all, grow/merge odd contexts, peel, result.
  task automatic build_model();
    int ctx, g, to, q, k, b, o;
    int odd [2];
    int visits [2];
    bit all0;
    e_stage.delete(); e_ctx.delete(); e_grow.delete(); e_to.delete();
    d_busy.delete(); d_odd.delete(); d_ready.delete();
    g = 0; to = 0;
    for (int c = 0; c < 2; c++) begin odd[c] = (c < m_nc) ? 1 : 0; visits[c] = 0; end
    for (int c = 0; c < m_nc; c++) begin
      push(STAGE_MEASUREMENT_LOADING, c, 0, 0, rnd(), rnd(), rnd());
      if (m_nc > 1) push(STAGE_WRITE_TO_MEM, c, 0, 0, rnd(), rnd(), rnd());
    end
    ctx = 0;
    forever begin
      g = (g < 63) ? g + 1 : 63;
      repeat (2) push(STAGE_GROW, ctx, g, to, rnd(), rnd(), rnd());
      q = 0; k = 0;
      while (q < 3) begin
        b = busy_at(k);
        q = (b != 0) ? 0 : q + 1;
        k++;
        o = (q == 3) ? ((visits[ctx] < odd_limit[ctx]) ? 1 : 0) : rnd();
        push(STAGE_MERGE, ctx, g, to, b, o, rnd());
      end
      odd[ctx] = (visits[ctx] < odd_limit[ctx]) ? 1 : 0;
      visits[ctx]++;
      all0 = 1'b1;
      for (int c = 0; c < m_nc; c++) if (odd[c] != 0) all0 = 1'b0;
      if (all0) break;
      if (g == m_maxg) begin to = 1; break; end
      if (m_nc > 1) begin
        do begin
          push(STAGE_WRITE_TO_MEM, ctx, g, to, rnd(), rnd(), rnd());
          ctx = (ctx + 1) % m_nc;
        end while (odd[ctx] == 0);
      end
    end
    for (int p = 0; p < m_nc; p++) begin
      push(STAGE_PEELING, ctx, g, to, rnd(), rnd(), rnd());
      if (m_nc > 1) begin
        push(STAGE_WRITE_TO_MEM, ctx, g, to, rnd(), rnd(), rnd());
        ctx = (ctx + 1) % m_nc;
      end
    end
    for (int d = 0; d <= rdy_delay; d++)
      push(STAGE_RESULT_VALID, ctx, g, to, rnd(), rnd(), (d == rdy_delay) ? 1 : 0);
    push(STAGE_RESET_ROOTS, ctx, g, to, rnd(), rnd(), rnd());
    push(STAGE_IDLE, 0, g, to, rnd(), rnd(), rnd());
  endtask

  // Starts a round on the selected DUT and checks every cycle against the model.
  task automatic run_round(input string name);
    int n, guard;
    logic [12:0] got, want;
    build_model();
    guard = 0;
    while (m_sr !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (m_sr !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_wait start_ready=%0b required 1", name, m_sr);
    end
    @(negedge clk);
    tb_start = 1'b1;
    n = e_stage.size();
    obs_merge = 0; obs_peel = 0; obs_grow_c1 = 0;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      got  = {m_stage, m_ctx, m_grow, m_to, m_rv, m_sr};
      want = {3'(e_stage[t]), 1'(e_ctx[t]), 6'(e_grow[t]), 1'(e_to[t]),
              e_stage[t] == int'(STAGE_RESULT_VALID), e_stage[t] == int'(STAGE_IDLE)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s t=%0d got stage=%0d ctx=%0d grow=%0d to=%0b rv=%0b sr=%0b required stage=%0d ctx=%0d grow=%0d to=%0b rv=%0b sr=%0b",
                 name, t, got[12:10], got[9], got[8:3], got[2], got[1], got[0],
                 want[12:10], want[9], want[8:3], want[2], want[1], want[0]);
      end
      if (m_stage == STAGE_MERGE)   obs_merge++;
      if (m_stage == STAGE_PEELING) obs_peel++;
      if (m_stage == STAGE_GROW && m_ctx == 1'b1) obs_grow_c1++;
      obs_last_grow = int'(m_grow);
      tb_start = (t == n - 1) ? 1'b0 : 1'(rnd());
      tb_busy  = 1'(d_busy[t]);
      tb_odd   = 1'(d_odd[t]);
      tb_ready = 1'(d_ready[t]);
    end
    tb_start = 1'b0; tb_busy = 1'b0; tb_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if ({m_stage, m_ctx, m_grow, m_to, m_rv, m_sr} !== 13'd0) begin
        errors++;
        $display("FAIL reset dut=%0d stage=%0d ctx=%0d grow=%0d to=%0b rv=%0b sr=%0b required all 0",
                 s, m_stage, m_ctx, m_grow, m_to, m_rv, m_sr);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if (m_sr !== 1'b1 || m_stage !== STAGE_IDLE) begin
        errors++;
        $display("FAIL reset_release dut=%0d sr=%0b stage=%0d required sr=1 stage=0", s, m_sr, m_stage);
      end
    end
  endtask

  task automatic test_single_pass();
    sel = 0; m_nc = 1; m_maxg = 63; busy_mode = 0; rdy_delay = 0; odd_limit[0] = 0;
    run_round("single_pass");
    checks++;
    if (obs_merge != 3) begin errors++; $display("FAIL single_pass merge_cycles=%0d required 3", obs_merge); end
  endtask

  task automatic test_multi_grow();
    sel = 0; m_nc = 1; m_maxg = 63; busy_mode = 0; rdy_delay = 1; odd_limit[0] = 3;
    run_round("multi_grow");
    checks++;
    if (obs_last_grow != 4) begin errors++; $display("FAIL multi_grow grow_count=%0d required 4", obs_last_grow); end
  endtask

  task automatic test_busy_extend();
    sel = 0; m_nc = 1; m_maxg = 63; rdy_delay = 0; odd_limit[0] = 0;
    busy_mode = 2;
    run_round("busy_5");
    checks++;
    if (obs_merge != 8) begin errors++; $display("FAIL busy_5 merge_cycles=%0d required 8", obs_merge); end
    busy_mode = 3;
    run_round("busy_glitch");
    checks++;
    if (obs_merge != 6) begin errors++; $display("FAIL busy_glitch merge_cycles=%0d required 6", obs_merge); end
  endtask

  task automatic test_two_contexts();
    sel = 1; m_nc = 2; m_maxg = 63; busy_mode = 0; rdy_delay = 0;
    odd_limit[0] = 2; odd_limit[1] = 0;
    run_round("two_ctx");
    checks++;
    if (obs_grow_c1 != 2 || obs_peel != 2) begin
      errors++;
      $display("FAIL two_ctx ctx1_grow_cycles=%0d peels=%0d required 2 and 2", obs_grow_c1, obs_peel);
    end
  endtask

  task automatic test_timeout();
    sel = 2; m_nc = 1; m_maxg = 3; busy_mode = 1; rdy_delay = 4; odd_limit[0] = 1000;
    run_round("timeout");
    checks++;
    if (m_to !== 1'b1) begin errors++; $display("FAIL timeout sticky=%0b required 1", m_to); end
    busy_mode = 0; rdy_delay = 0; odd_limit[0] = 0;
    run_round("timeout_clear");
  endtask

  task automatic test_reset_mid_merge();
    int guard;
    sel = 1; tb_busy = 1'b1;
    @(negedge clk); tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0;
    guard = 0;
    while (m_stage !== STAGE_MERGE && guard < 30) begin @(negedge clk); guard++; end
    checks++;
    if (m_stage !== STAGE_MERGE) begin
      errors++;
      $display("FAIL reach_merge stage=%0d required %0d", m_stage, STAGE_MERGE);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_stage !== STAGE_IDLE || m_rv !== 1'b0 || m_grow !== 6'd0 || m_ctx !== 1'b0) begin
      errors++;
      $display("FAIL async_reset stage=%0d rv=%0b grow=%0d ctx=%0d required 0 0 0 0", m_stage, m_rv, m_grow, m_ctx);
    end
    @(negedge clk); rst_n = 1'b1; tb_busy = 1'b0;
    m_nc = 2; m_maxg = 63; busy_mode = 1; rdy_delay = 2; odd_limit[0] = 1; odd_limit[1] = 1;
    run_round("after_reset");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      sel = r % 2; m_nc = sel + 1; m_maxg = 63; busy_mode = 1;
      rdy_delay = int'($urandom_range(0, 3));
      odd_limit[0] = int'($urandom_range(0, 3));
      odd_limit[1] = int'($urandom_range(0, 3));
      run_round($sformatf("random%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_grow();
    test_busy_extend();
    test_two_contexts();
    test_timeout();
    test_reset_mid_merge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
